// File: rtl/mem_bist_master.sv
// Memory BIST master for a flat SRAM-style bus: writes a data pattern over an
// address range, reads it back, and reports the first mismatch or timeout.
module mem_bist_master #(
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT        = 255,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [1:0]        pattern,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_exp,
    output logic [7:0]        err_got,
    output logic              CEb_out,
    output logic              WEb_out,
    output logic [ADDR_W-1:0] A_out,
    inout  wire  [7:0]        Q_f,
    input  logic              ready
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int REL_W = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, W_ARM, W_LO, W_HI, W_REL, R_ARM, R_LO, R_HI, R_REL, FIN
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cur_reg, cur_next;
    logic [ADDR_W-1:0]   first_reg, first_next;
    logic [ADDR_W-1:0]   last_reg, last_next;
    logic [1:0]          pat_reg, pat_next;
    logic                ceb_reg, ceb_next;
    logic                web_reg, web_next;
    logic [ADDR_W-1:0]   a_reg, a_next;
    logic [7:0]          wdata_reg, wdata_next;
    logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [REL_W-1:0]    rel_cnt_reg, rel_cnt_next;
    logic [1:0]          err_code_reg, err_code_next;
    logic [ADDR_W-1:0]   err_addr_reg, err_addr_next;
    logic [7:0]          err_exp_reg, err_exp_next;
    logic [7:0]          err_got_reg, err_got_next;

    logic                timed_out;
    logic                rel_done;
    logic                fire_timeout;
    logic [ADDR_W-1:0]   cur_inc;
    logic [7:0]          cur_exp;

    function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] addr,
                                            input logic [1:0] pat);
        logic [15:0] a16;
        logic [7:0]  res;
        a16 = 16'(addr);
        unique case (pat)
            2'd0: res = a16[7:0] ^ a16[15:8];
            2'd1: res = ~(a16[7:0] ^ a16[15:8]);
            2'd2: res = a16[0] ? 8'hAA : 8'h55;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    assign timed_out = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
    assign rel_done  = (32'(rel_cnt_reg) + 32'd1 >= 32'(RELEASE_CYCLES));
    assign cur_inc   = cur_reg + ADDR_W'(1);
    assign cur_exp   = exp_byte(cur_reg, pat_reg);

    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        first_next    = first_reg;
        last_next     = last_reg;
        pat_next      = pat_reg;
        ceb_next      = ceb_reg;
        web_next      = web_reg;
        a_next        = a_reg;
        wdata_next    = wdata_reg;
        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        rel_cnt_next  = rel_cnt_reg + REL_W'(1);
        err_code_next = err_code_reg;
        err_addr_next = err_addr_reg;
        err_exp_next  = err_exp_reg;
        err_got_next  = err_got_reg;
        fire_timeout  = 1'b0;

        // Address and WEb are set up on ARM entry while CEb is still high,
        // so CEb only ever falls onto an already-stable command.
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    err_addr_next = '0;
                    err_exp_next  = '0;
                    err_got_next  = '0;
                    if (last_addr < first_addr) begin
                        err_code_next = 2'd3;
                        state_next    = FIN;
                    end else begin
                        err_code_next = 2'd0;
                        cur_next      = first_addr;
                        first_next    = first_addr;
                        last_next     = last_addr;
                        pat_next      = pattern;
                        a_next        = first_addr;
                        web_next      = 1'b0;
                        wdata_next    = exp_byte(first_addr, pattern);
                        wait_cnt_next = '0;
                        state_next    = W_ARM;
                    end
                end
            end
            W_ARM, R_ARM: begin
                if (ready) begin
                    ceb_next      = 1'b0;
                    wait_cnt_next = '0;
                    state_next    = (state_reg == W_ARM) ? W_LO : R_LO;
                end else if (timed_out) begin
                    fire_timeout = 1'b1;
                end
            end
            W_LO, R_LO: begin
                if (!ready) begin
                    wait_cnt_next = '0;
                    state_next    = (state_reg == W_LO) ? W_HI : R_HI;
                end else if (timed_out) begin
                    fire_timeout = 1'b1;
                end
            end
            W_HI: begin
                if (ready) begin
                    ceb_next     = 1'b1;
                    web_next     = 1'b1;
                    rel_cnt_next = '0;
                    state_next   = W_REL;
                end else if (timed_out) begin
                    fire_timeout = 1'b1;
                end
            end
            R_HI: begin
                if (ready) begin
                    ceb_next = 1'b1;
                    if (Q_f != cur_exp) begin
                        err_code_next = 2'd1;
                        err_addr_next = cur_reg;
                        err_exp_next  = cur_exp;
                        err_got_next  = Q_f;
                        state_next    = FIN;
                    end else begin
                        rel_cnt_next = '0;
                        state_next   = R_REL;
                    end
                end else if (timed_out) begin
                    fire_timeout = 1'b1;
                end
            end
            W_REL: begin
                if (rel_done) begin
                    wait_cnt_next = '0;
                    if (cur_reg == last_reg) begin
                        cur_next   = first_reg;
                        a_next     = first_reg;
                        web_next   = 1'b1;
                        state_next = R_ARM;
                    end else begin
                        cur_next   = cur_inc;
                        a_next     = cur_inc;
                        web_next   = 1'b0;
                        wdata_next = exp_byte(cur_inc, pat_reg);
                        state_next = W_ARM;
                    end
                end
            end
            R_REL: begin
                if (rel_done) begin
                    wait_cnt_next = '0;
                    if (cur_reg == last_reg) begin
                        state_next = FIN;
                    end else begin
                        cur_next   = cur_inc;
                        a_next     = cur_inc;
                        state_next = R_ARM;
                    end
                end
            end
            FIN: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (fire_timeout) begin
            ceb_next      = 1'b1;
            web_next      = 1'b1;
            err_code_next = 2'd2;
            err_addr_next = cur_reg;
            state_next    = FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cur_reg      <= '0;
            first_reg    <= '0;
            last_reg     <= '0;
            pat_reg      <= '0;
            ceb_reg      <= 1'b1;
            web_reg      <= 1'b1;
            a_reg        <= '0;
            wdata_reg    <= '0;
            wait_cnt_reg <= '0;
            rel_cnt_reg  <= '0;
            err_code_reg <= '0;
            err_addr_reg <= '0;
            err_exp_reg  <= '0;
            err_got_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            first_reg    <= first_next;
            last_reg     <= last_next;
            pat_reg      <= pat_next;
            ceb_reg      <= ceb_next;
            web_reg      <= web_next;
            a_reg        <= a_next;
            wdata_reg    <= wdata_next;
            wait_cnt_reg <= wait_cnt_next;
            rel_cnt_reg  <= rel_cnt_next;
            err_code_reg <= err_code_next;
            err_addr_reg <= err_addr_next;
            err_exp_reg  <= err_exp_next;
            err_got_reg  <= err_got_next;
        end
    end

    assign busy     = (state_reg != IDLE) && (state_reg != FIN);
    assign done     = (state_reg == FIN);
    assign err_code = err_code_reg;
    assign err_addr = err_addr_reg;
    assign err_exp  = err_exp_reg;
    assign err_got  = err_got_reg;
    assign CEb_out  = ceb_reg;
    assign WEb_out  = web_reg;
    assign A_out    = a_reg;
    assign Q_f      = (!ceb_reg && !web_reg) ? wdata_reg : 8'hzz;

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed bench for mem_bist_master with a behavioural ready/data controller model.
module tb_mem_bist_master;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [1:0]    pattern = '0;
    logic          busy, done, ceb, web;
    logic [1:0]    err_code;
    logic [AW-1:0] err_addr, dut_a;
    logic [7:0]    err_exp, err_got;
    wire  [7:0]    q_f;
    logic          ready;

    logic          stall = 1'b0;
    logic          corrupt_en = 1'b0;
    logic          stat_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    mem_bist_master #(.ADDR_W(AW), .TIMEOUT(255), .RELEASE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr), .pattern(pattern),
        .busy(busy), .done(done), .err_code(err_code),
        .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
        .CEb_out(ceb), .WEb_out(web), .A_out(dut_a),
        .Q_f(q_f), .ready(ready)
    );

    always #5 clk = ~clk;

    // Controller model: accepts a command when CEb is low, completes it three
    // cycles later, and serves read data from a 256-byte array.
    logic [7:0]    mem [0:255];
    logic [7:0]    rd_byte;
    int            m_st, m_cnt;
    int            n_wr, n_rd, n_fall, viol, hi_run, min_gap;
    logic [AW-1:0] last_wr_addr, last_rd_addr, a_hold;
    logic          prev_ceb, prev_web, web_hold, had_txn;

    assign rd_byte = (corrupt_en && dut_a[7:0] == 8'h12) ? 8'hFF : mem[dut_a[7:0]];
    assign q_f = (!ceb && web) ? rd_byte : 8'hzz;

    always @(posedge clk) begin
        if (reset) begin
            m_st  <= 0;
            m_cnt <= 0;
            ready <= 1'b1;
        end else begin
            case (m_st)
                0: if (!ceb && ready && !stall) begin
                    ready <= 1'b0;
                    m_cnt <= 0;
                    m_st  <= 1;
                end
                1: if (m_cnt == 2) begin
                    ready <= 1'b1;
                    m_st  <= 2;
                    if (!web) begin
                        mem[dut_a[7:0]] <= q_f;
                        n_wr <= n_wr + 1;
                        last_wr_addr <= dut_a;
                        if (n_rd != 0) viol <= viol + 1;
                    end else begin
                        n_rd <= n_rd + 1;
                        last_rd_addr <= dut_a;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (ceb) m_st <= 0;
            endcase
        end
        if (stat_clr) begin
            n_wr <= 0; n_rd <= 0; n_fall <= 0; viol <= 0;
            hi_run <= 0; min_gap <= 999; had_txn <= 1'b0;
            last_wr_addr <= '0; last_rd_addr <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'hC3;
        end else if (!reset) begin
            if (ceb) begin
                hi_run <= hi_run + 1;
            end else if (prev_ceb) begin
                n_fall <= n_fall + 1;
                if (had_txn && hi_run < min_gap) min_gap <= hi_run;
                had_txn <= 1'b1;
                hi_run  <= 0;
                a_hold  <= dut_a;
                web_hold <= web;
                if (web != prev_web) viol <= viol + 1;
            end else if (dut_a != a_hold || web != web_hold) begin
                viol <= viol + 1;
            end
        end
        prev_ceb <= ceb;
        prev_web <= web;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        @(negedge clk); stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
    endtask

    task automatic run(input logic [AW-1:0] f, input logic [AW-1:0] l, input logic [1:0] p,
                       input bit poke, output int cyc);
        @(negedge clk);
        first_addr = f; last_addr = l; pattern = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 5000) begin
            if (poke && cyc == 20) begin
                first_addr = '0; last_addr = '0; pattern = 2'd3; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int cyc;
        stat_clr = 1'b1;
        repeat (3) @(negedge clk);
        stat_clr = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ceb", ceb, 1);
        check("rst_web", web, 1);
        check("rst_a", 32'(dut_a), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_code", err_code, 0);
        check("rst_err_addr", 32'(err_addr), 0);

        // Pattern 0 pass over 0x10..0x13 with an ignored start mid-run
        clear_stats();
        @(negedge clk);
        first_addr = 23'h10; last_addr = 23'h13; pattern = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        run(23'h10, 23'h13, 2'd0, 1'b1, cyc);
        check("p0_err_code", err_code, 0);
        check("p0_busy_at_done", busy, 0);
        check("p0_writes", n_wr, 4);
        check("p0_reads", n_rd, 4);
        check("p0_mem10", mem[8'h10], 8'h10);
        check("p0_mem13", mem[8'h13], 8'h13);
        check("p0_min_gap_ge2", (min_gap >= 2) ? 1 : 0, 1);
        check("p0_bus_rules", viol, 0);
        @(negedge clk);
        check("p0_done_pulse", done, 0);

        // Pattern 2 with the read at 0x12 corrupted
        clear_stats();
        corrupt_en = 1'b1;
        run(23'h10, 23'h13, 2'd2, 1'b0, cyc);
        corrupt_en = 1'b0;
        check("mm_err_code", err_code, 1);
        check("mm_err_addr", 32'(err_addr), 32'h12);
        check("mm_err_exp", err_exp, 8'h55);
        check("mm_err_got", err_got, 8'hFF);
        check("mm_ceb", ceb, 1);
        check("mm_reads", n_rd, 3);
        check("mm_last_rd", 32'(last_rd_addr), 32'h12);
        check("mm_mem11", mem[8'h11], 8'hAA);
        repeat (10) @(negedge clk);
        check("mm_no_more_access", n_fall, 7);

        // Controller never accepts: timeout in W_LO
        clear_stats();
        stall = 1'b1;
        @(negedge clk);
        first_addr = 23'h20; last_addr = 23'h20; pattern = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (ceb && cyc < 50) begin @(negedge clk); cyc++; end
        check("to_ceb_fell", ceb, 0);
        cyc = 0;
        while (!done && cyc < 1000) begin @(negedge clk); cyc++; end
        check("to_cycles", cyc, 255);
        check("to_err_code", err_code, 2);
        check("to_err_addr", 32'(err_addr), 32'h20);
        check("to_ceb_high", ceb, 1);
        check("to_web_high", web, 1);
        stall = 1'b0;

        // Bad range
        clear_stats();
        run(23'h5, 23'h4, 2'd0, 1'b0, cyc);
        check("br_cycles", cyc, 1);
        check("br_err_code", err_code, 3);
        check("br_busy", busy, 0);
        check("br_ceb_never_low", n_fall, 0);

        // Reset while the read of 0x30 sits in R_HI
        clear_stats();
        @(negedge clk);
        first_addr = 23'h30; last_addr = 23'h31; pattern = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(!ceb && web && !ready) && cyc < 500) begin @(negedge clk); cyc++; end
        check("rh_reached_read", (!ceb && web && !ready) ? 1 : 0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rh_ceb", ceb, 1);
        check("rh_busy", busy, 0);
        check("rh_done", done, 0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rh_no_done", done, 0);
        end
        clear_stats();
        run(23'h40, 23'h41, 2'd1, 1'b0, cyc);
        check("rh2_err_code", err_code, 0);
        check("rh2_writes", n_wr, 2);
        check("rh2_reads", n_rd, 2);
        check("rh2_mem40", mem[8'h40], 8'hBF);
        check("rh2_mem41", mem[8'h41], 8'hBE);

        // Single address at the top of the space, pattern 3
        clear_stats();
        run(23'h7FFFFF, 23'h7FFFFF, 2'd3, 1'b0, cyc);
        check("top_err_code", err_code, 0);
        check("top_writes", n_wr, 1);
        check("top_reads", n_rd, 1);
        check("top_wr_addr", 32'(last_wr_addr), 32'h7FFFFF);
        check("top_memFF", mem[8'hFF], 8'h00);
        check("top_bus_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bist_master.md
MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 Parameter ADDR_W, default 23, flat-bus address width.
REQ-002 Parameter TIMEOUT, default 255, max clk cycles spent waiting on one ready transition.
REQ-003 Parameter RELEASE_CYCLES, default 2, minimum clk cycles CEb_out is held high between transactions.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a test; ignored unless busy=0.
REQ-007 first_addr  input  ADDR_W  first tested address, inclusive; sampled on start.
REQ-008 last_addr  input  ADDR_W  last tested address, inclusive; sampled on start.
REQ-009 pattern  input  2  data pattern select; sampled on start.
REQ-010 busy  output  1  high from the cycle after start until done.
REQ-011 done  output  1  one-cycle pulse at test end.
REQ-012 err_code  output  2  0 pass, 1 mismatch, 2 timeout, 3 bad range; held until next start.
REQ-013 err_addr / err_exp / err_got  output  ADDR_W/8/8  first failing address, expected byte, read byte.
REQ-014 CEb_out  output  1  flat-bus chip enable, active low.
REQ-015 WEb_out  output  1  flat-bus write enable, active low.
REQ-016 A_out  output  ADDR_W  flat-bus address.
REQ-017 Q_f  inout  8  flat-bus data; driven only when CEb_out=0 and WEb_out=0, else high-Z.
REQ-018 ready  input  1  controller ready; falls when a command is accepted, rises when it completes.

Function
REQ-019 Expected byte: pattern 0 = A[7:0]^A[15:8]; 1 = ~(A[7:0]^A[15:8]); 2 = 8'h55 for even A, 8'hAA for odd A; 3 = 8'h00.
REQ-020 States: IDLE, W_ARM, W_LO, W_HI, W_REL, R_ARM, R_LO, R_HI, R_REL, FIN.
REQ-021 IDLE + start: last_addr < first_addr -> FIN with err_code=3, no bus activity; otherwise cur=first_addr, clear err fields, -> W_ARM.
REQ-022 W_ARM: wait until ready=1, then drive A_out=cur, WEb_out=0, Q_f=pattern byte, CEb_out=0 -> W_LO.
REQ-023 W_LO: wait for ready=0 -> W_HI; W_HI: wait for ready=1 -> W_REL, driving CEb_out=1 and WEb_out=1 on that transition.
REQ-024 W_REL: hold CEb_out=1 for RELEASE_CYCLES cycles, then cur==last_addr ? (cur=first_addr, -> R_ARM) : (cur+1, -> W_ARM).
REQ-025 R_ARM/R_LO/R_HI/R_REL mirror the write states with WEb_out=1 and Q_f released.
REQ-026 In R_HI, the cycle ready=1 is first seen, sample Q_f and compare with the expected byte for cur.
REQ-027 Mismatch: latch err_addr=cur, err_exp, err_got; err_code=1; CEb_out=1; -> FIN, skipping the remaining addresses.
REQ-028 After the R_REL of last_addr with no mismatch -> FIN with err_code=0.
REQ-029 A wait counter is cleared on entry to every ARM/LO/HI state; reaching TIMEOUT -> CEb_out=1, WEb_out=1, err_code=2, err_addr=cur, -> FIN.
REQ-030 FIN: done=1 for one cycle, busy=0, -> IDLE.
REQ-031 A_out and WEb_out are stable for the whole interval CEb_out=0; CEb_out never falls in the same cycle WEb_out changes.
REQ-032 Address increment is ADDR_W bits; last_addr=all-ones terminates without wrap.
REQ-033 start while busy=1 is ignored; start and reset in the same cycle: reset wins.

Reset
REQ-034 reset -> IDLE; CEb_out=1, WEb_out=1, A_out=0, Q_f high-Z, busy=0, done=0, err_code=0, err_addr/err_exp/err_got=0.
REQ-035 reset mid-transaction aborts immediately with CEb_out=1 in the next cycle; no done pulse.

Verification
REQ-036 Controller model, first=0x10, last=0x13, pattern 0 -> 4 writes then 4 reads; done with err_code=0; CEb high >=2 cycles between transactions.
REQ-037 Model corrupts the read at 0x12 to 0xFF, pattern 2 -> err_code=1, err_addr=0x12, err_exp=0x55, err_got=0xFF; no access to 0x13 afterwards.
REQ-038 ready held at 1 after a write is issued -> err_code=2 after 255 cycles in W_LO, CEb_out=1.
REQ-039 first=5, last=4 -> done the next cycle with err_code=3, CEb_out never low.
REQ-040 reset asserted while in R_HI -> next cycle CEb_out=1, busy=0, Q_f high-Z; a new start runs cleanly.
REQ-041 first=last=all-ones, pattern 3 -> one write and one read, err_code=0, no address wrap.
